// File: rtl/arb_burst_mux.sv
// arb_burst_mux: moves one fixed-length burst per arbiter grant onto a shared registered stream
module arb_burst_mux #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic [DATA_W-1:0] data_0,
    input  logic              valid_0,
    output logic              ready_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic              valid_1,
    output logic              ready_1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_owner,
    input  logic              out_ready,
    output logic              done_0,
    output logic              done_1,
    output logic              err
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LEN  = CW'(BURST_LEN);
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] data_own;
    logic gnt_own, gnt_oth, valid_own, rdy, take, drain;
    // owner-relative views of the client ports plus the accept condition
    always_comb begin
        gnt_own   = out_owner ? gnt_1 : gnt_0;
        gnt_oth   = out_owner ? gnt_0 : gnt_1;
        valid_own = out_owner ? valid_1 : valid_0;
        data_own  = out_owner ? data_1 : data_0;
        rdy       = (state == XFER) && (!out_valid || out_ready) && (cnt < LEN);
        ready_0   = rdy && !out_owner;
        ready_1   = rdy && out_owner;
        take      = rdy && valid_own;
        drain     = out_valid && out_ready;
    end
    // next state: losing the grant always wins over burst completion
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (gnt_0 ^ gnt_1) ? XFER : IDLE;
            XFER:    state_nx = !gnt_own ? IDLE : (drain && out_last) ? RELEASE : XFER;
            RELEASE: state_nx = !gnt_own ? IDLE : RELEASE;
            default: state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // datapath: owner latch, beat counter, output register, done pulses and sticky error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_owner <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;
            err       <= 1'b0;
        end else begin
            done_0 <= 1'b0;
            done_1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_0 && gnt_1) err <= 1'b1;
                    else if (gnt_0 || gnt_1) begin
                        out_owner <= gnt_1;
                        cnt       <= '0;
                    end
                end
                XFER: begin
                    if (!gnt_own) begin
                        err       <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        if (gnt_oth) err <= 1'b1;
                        if (take) begin
                            out_data  <= data_own;
                            out_valid <= 1'b1;
                            out_last  <= (cnt == LAST);
                            cnt       <= cnt + CW'(1);
                        end else if (drain) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                        if (drain && out_last) begin
                            done_0 <= !out_owner;
                            done_1 <= out_owner;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arb_burst_mux.sv
// tb_arb_burst_mux: directed scenario tests for arb_burst_mux
module tb_arb_burst_mux;
    logic clock = 1'b0, reset = 1'b1;
    logic gnt_0 = 1'b0, gnt_1 = 1'b0, valid_0 = 1'b0, valid_1 = 1'b0, out_ready = 1'b0;
    logic [7:0] data_0 = 8'h00, data_1 = 8'h00;
    logic ready_0, ready_1, out_valid, out_last, out_owner, done_0, done_1, err;
    logic [7:0] out_data;
    logic b_ready_0, b_ready_1, b_out_valid, b_out_last, b_out_owner, b_done_0, b_done_1, b_err;
    logic [7:0] b_out_data;
    int checks = 0, errors = 0;

    arb_burst_mux #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clock(clock), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .data_0(data_0), .valid_0(valid_0), .ready_0(ready_0),
        .data_1(data_1), .valid_1(valid_1), .ready_1(ready_1),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_owner(out_owner),
        .out_ready(out_ready), .done_0(done_0), .done_1(done_1), .err(err)
    );

    arb_burst_mux #(.DATA_W(8), .BURST_LEN(1)) dut1 (
        .clock(clock), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .data_0(data_0), .valid_0(valid_0), .ready_0(b_ready_0),
        .data_1(data_1), .valid_1(valid_1), .ready_1(b_ready_1),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last), .out_owner(b_out_owner),
        .out_ready(out_ready), .done_0(b_done_0), .done_1(b_done_1), .err(b_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        tick();
        checks++; if ({out_valid, out_last, out_owner, ready_0, ready_1, done_0, done_1, err, out_data} !== 16'h0) begin errors++; $display("FAIL reset_outputs: got %h, expected 0000", {out_valid, out_last, out_owner, ready_0, ready_1, done_0, done_1, err, out_data}); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] v [4];
        v = '{8'h11, 8'h22, 8'h33, 8'h44};
        gnt_0 = 1'b1; valid_0 = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (ready_0 !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b, expected 1", ready_0); end
        checks++; if (ready_1 !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b, expected 0", ready_1); end
        for (int i = 0; i < 4; i++) begin
            data_0 = v[i];
            tick();
            checks++; if (out_data !== v[i]) begin errors++; $display("FAIL single_data%0d: got %h, expected %h", i, out_data, v[i]); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid%0d: got %b, expected 1", i, out_valid); end
            checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL single_last%0d: got %b, expected %b", i, out_last, (i == 3)); end
            checks++; if (done_0 !== 1'b0) begin errors++; $display("FAIL single_early_done%0d: got %b, expected 0", i, done_0); end
            if (i == 0) begin
                checks++; if ({b_out_data, b_out_last, b_out_valid} !== {8'h11, 2'b11}) begin errors++; $display("FAIL len1_beat: got %h/%b/%b, expected 11/1/1", b_out_data, b_out_last, b_out_valid); end
            end
            if (i == 1) begin
                checks++; if (b_done_0 !== 1'b1) begin errors++; $display("FAIL len1_done: got %b, expected 1", b_done_0); end
            end
            if (i == 2) begin
                checks++; if ({b_done_0, b_ready_0, b_out_valid} !== 3'b000) begin errors++; $display("FAIL len1_release: got %b, expected 000", {b_done_0, b_ready_0, b_out_valid}); end
            end
        end
        checks++; if (out_owner !== 1'b0) begin errors++; $display("FAIL single_owner: got %b, expected 0", out_owner); end
        valid_0 = 1'b0;
        tick();
        checks++; if ({done_0, done_1, out_valid, ready_0} !== 4'b1000) begin errors++; $display("FAIL single_done: got %b, expected 1000", {done_0, done_1, out_valid, ready_0}); end
        gnt_0 = 1'b0;
        tick();
        checks++; if ({done_0, err} !== 2'b00) begin errors++; $display("FAIL single_after: got %b, expected 00", {done_0, err}); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v [4];
        v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        gnt_1 = 1'b1; valid_1 = 1'b1; data_1 = v[0];
        tick();
        checks++; if ({out_owner, ready_1, ready_0} !== 3'b110) begin errors++; $display("FAIL bp_start: got %b, expected 110", {out_owner, ready_1, ready_0}); end
        tick();
        out_ready = 1'b0; data_1 = v[1];
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (ready_1 !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b, expected 0", k, ready_1); end
            tick();
            checks++; if ({out_data, out_valid, out_last} !== {v[0], 2'b10}) begin errors++; $display("FAIL bp_hold%0d: got %h/%b/%b, expected a1/1/0", k, out_data, out_valid, out_last); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (ready_1 !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b, expected 1", ready_1); end
        for (int i = 1; i < 4; i++) begin
            data_1 = v[i];
            tick();
            checks++; if ({out_data, out_valid, out_last} !== {v[i], 1'b1, (i == 3)}) begin errors++; $display("FAIL bp_beat%0d: got %h/%b/%b, expected %h/1/%b", i, out_data, out_valid, out_last, v[i], (i == 3)); end
        end
        valid_1 = 1'b0;
        tick();
        checks++; if ({done_1, done_0} !== 2'b10) begin errors++; $display("FAIL bp_done: got %b, expected 10", {done_1, done_0}); end
        gnt_1 = 1'b0;
        tick();
        checks++; if (done_1 !== 1'b0) begin errors++; $display("FAIL bp_done_width: got %b, expected 0", done_1); end
    endtask

    task automatic test_release();
        logic [7:0] v [4];
        v = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        gnt_0 = 1'b1; valid_0 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            data_0 = v[i];
            tick();
        end
        valid_0 = 1'b0;
        tick();
        checks++; if (done_0 !== 1'b1) begin errors++; $display("FAIL rel_done: got %b, expected 1", done_0); end
        valid_1 = 1'b1; data_1 = 8'hD1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if ({ready_0, ready_1, done_0, out_valid} !== 4'b0000) begin errors++; $display("FAIL rel_hold%0d: got %b, expected 0000", k, {ready_0, ready_1, done_0, out_valid}); end
        end
        gnt_0 = 1'b0; gnt_1 = 1'b1;
        tick();
        checks++; if ({ready_1, out_owner} !== 2'b00) begin errors++; $display("FAIL rel_idle: got %b, expected 00", {ready_1, out_owner}); end
        tick();
        checks++; if ({ready_1, out_owner} !== 2'b11) begin errors++; $display("FAIL rel_regrant: got %b, expected 11", {ready_1, out_owner}); end
        for (int i = 0; i < 4; i++) begin
            data_1 = v[i] ^ 8'hFF;
            tick();
            checks++; if (out_data !== (v[i] ^ 8'hFF)) begin errors++; $display("FAIL rel_beat%0d: got %h, expected %h", i, out_data, v[i] ^ 8'hFF); end
        end
        valid_1 = 1'b0;
        tick();
        checks++; if ({done_1, err} !== 2'b10) begin errors++; $display("FAIL rel_done1: got %b, expected 10", {done_1, err}); end
        gnt_1 = 1'b0;
        tick();
    endtask

    task automatic test_grant_drop();
        gnt_0 = 1'b1; valid_0 = 1'b1; data_0 = 8'h01;
        tick();
        tick();
        data_0 = 8'h02;
        tick();
        checks++; if ({out_data, out_valid} !== {8'h02, 1'b1}) begin errors++; $display("FAIL drop_pre: got %h/%b, expected 02/1", out_data, out_valid); end
        gnt_0 = 1'b0; valid_0 = 1'b0;
        tick();
        checks++; if ({err, out_valid, out_last, done_0} !== 4'b1000) begin errors++; $display("FAIL drop_abort: got %b, expected 1000", {err, out_valid, out_last, done_0}); end
        tick();
        checks++; if (done_0 !== 1'b0) begin errors++; $display("FAIL drop_no_done: got %b, expected 0", done_0); end
        gnt_1 = 1'b1; valid_1 = 1'b1;
        tick();
        checks++; if ({out_owner, ready_1} !== 2'b11) begin errors++; $display("FAIL drop_next_owner: got %b, expected 11", {out_owner, ready_1}); end
        for (int i = 0; i < 4; i++) begin
            data_1 = 8'hB0 + 8'(i);
            tick();
            checks++; if ({out_data, out_last} !== {8'hB0 + 8'(i), (i == 3)}) begin errors++; $display("FAIL drop_beat%0d: got %h/%b, expected %h/%b", i, out_data, out_last, 8'hB0 + 8'(i), (i == 3)); end
        end
        valid_1 = 1'b0;
        tick();
        checks++; if (done_1 !== 1'b1) begin errors++; $display("FAIL drop_done1: got %b, expected 1", done_1); end
        gnt_1 = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #4;
        reset = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_clears_err: got %b, expected 0", err); end
    endtask

    task automatic test_simultaneous();
        gnt_0 = 1'b1; gnt_1 = 1'b1; valid_0 = 1'b1; valid_1 = 1'b1;
        tick();
        checks++; if ({err, ready_0, ready_1, out_valid} !== 4'b1000) begin errors++; $display("FAIL both_grants: got %b, expected 1000", {err, ready_0, ready_1, out_valid}); end
        tick();
        checks++; if ({err, ready_0, ready_1, out_valid} !== 4'b1000) begin errors++; $display("FAIL both_grants_hold: got %b, expected 1000", {err, ready_0, ready_1, out_valid}); end
        gnt_0 = 1'b0; gnt_1 = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        gnt_0 = 1'b1; valid_0 = 1'b1; data_0 = 8'h55;
        tick();
        tick();
        data_0 = 8'h66;
        tick();
        checks++; if ({out_data, out_valid} !== {8'h66, 1'b1}) begin errors++; $display("FAIL ar_pre: got %h/%b, expected 66/1", out_data, out_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({out_valid, out_last, out_owner, ready_0, ready_1, done_0, done_1, err, out_data} !== 16'h0) begin errors++; $display("FAIL ar_immediate: got %h, expected 0000", {out_valid, out_last, out_owner, ready_0, ready_1, done_0, done_1, err, out_data}); end
        #2 reset = 1'b0; gnt_0 = 1'b0; valid_0 = 1'b0;
        tick();
        checks++; if ({out_valid, ready_0, done_0} !== 3'b000) begin errors++; $display("FAIL ar_idle: got %b, expected 000", {out_valid, ready_0, done_0}); end
        gnt_0 = 1'b1;
        tick();
        checks++; if (ready_0 !== 1'b1) begin errors++; $display("FAIL ar_regrant: got %b, expected 1", ready_0); end
        gnt_0 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_release();
        test_grant_drop();
        apply_reset();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_burst_mux.md
Name: arb_burst_mux

Overview:
- Downstream consumer of the 2-input arbiter's grants (gnt_0/gnt_1).
- When a client is granted, the block becomes the bus owner's data path: it moves exactly BURST_LEN beats from that client onto one shared registered output stream.
- It pulses done_x so the client drops its request. It then waits for the arbiter to release the grant before it accepts a new owner.

Parameters:
- DATA_W, 8, width of the client and output data.
- BURST_LEN, 4, beats per granted transaction. Legal range is 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- gnt_0  in  1  grant to client 0, from the arbiter.
- gnt_1  in  1  grant to client 1, from the arbiter.
- data_0  in  DATA_W  client 0 beat data.
- valid_0  in  1  client 0 beat valid.
- ready_0  out  1  client 0 beat accepted when valid_0 and ready_0 are both high.
- data_1  in  DATA_W  client 1 beat data.
- valid_1  in  1  client 1 beat valid.
- ready_1  out  1  client 1 beat accepted when valid_1 and ready_1 are both high.
- out_data  out  DATA_W  shared output data, registered.
- out_valid  out  1  output valid, registered.
- out_last  out  1  marks the final beat of a burst, registered.
- out_owner  out  1  client index of the current or last burst.
- out_ready  in  1  downstream accept.
- done_0  out  1  one-cycle pulse: client 0 burst complete.
- done_1  out  1  one-cycle pulse: client 1 burst complete.
- err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, and all of out_data, out_valid, out_last, out_owner, ready_x, done_x, err = 0.
- cnt width is ceil(log2(BURST_LEN+1)).
- The FSM has three states: IDLE, XFER, RELEASE.
- IDLE:
  - ready_x=0.
  - Exactly one gnt high: latch owner (out_owner<=index), cnt<=0, go to XFER.
  - Both gnt high: err<=1, stay in IDLE, no owner latched.
  - Neither gnt high: stay in IDLE.
- XFER, acceptance:
  - ready_owner = (!out_valid | out_ready) & (cnt < BURST_LEN).
  - The non-owner's ready is always 0.
- XFER, input handshake on the owner:
  - out_data<=data_owner, out_valid<=1, out_last<=(cnt==BURST_LEN-1), cnt<=cnt+1.
  - Latency is one cycle from input beat to output.
- XFER, output drain:
  - out_valid&out_ready with no new load: out_valid<=0, out_last<=0.
  - Full throughput is one beat per cycle while out_ready is high.
- XFER, backpressure: out_valid&!out_ready holds out_data/out_last stable and ready_owner=0.
- XFER, burst completion:
  - The burst completes when out_valid&out_ready&out_last.
  - On that cycle: done_owner<=1 (pulse on the next cycle, exactly one cycle wide), go to RELEASE.
- XFER, grant lost before completion (gnt_owner low):
  - err<=1, out_valid<=0, out_last<=0, cnt<=0, go to IDLE.
  - No done pulse. The pending output beat is discarded.
- XFER, non-owner grant rises while gnt_owner is still high: err<=1, transfer continues.
- RELEASE:
  - ready_x=0.
  - Wait until gnt_owner is low, then go to IDLE. This takes a minimum of one cycle.
  - A re-grant cannot be taken in the same cycle the old grant falls.
- Back-to-back bursts: IDLE samples the grants on the cycle after RELEASE exits. The owner may change.
- BURST_LEN=1: the single beat has out_last=1.
- out_owner holds its value after the burst until the next latch.
- Reset mid-burst: the output stream is truncated and no done pulse is issued.

Test Plan:
- Single burst, client 0:
  - Stimulus: BURST_LEN=4, gnt_0 held high, valid_0=1, data 0x11,0x22,0x33,0x44, out_ready=1.
  - Response: out_data 0x11..0x44 on four consecutive cycles starting one cycle after the first accept; out_last only on 0x44; done_0 pulses once; out_owner=0.
- Backpressure, client 1:
  - Stimulus: gnt_1, out_ready low for 3 cycles after the first beat.
  - Response: out_data=first beat stable and ready_1=0 throughout; the burst resumes and completes with 4 beats; done_1 pulses once.
- Simultaneous grants:
  - Stimulus: gnt_0=gnt_1=1 in IDLE.
  - Response: err=1; ready_0=ready_1=0; no out_valid.
- Grant dropped mid-burst:
  - Stimulus: gnt_0 falls after 2 accepted beats.
  - Response: err=1; out_valid=0 the next cycle; no done_0; FSM accepts a later gnt_1 burst normally.
- Release handling:
  - Stimulus: after done_0, keep gnt_0 high for 5 cycles, then assert gnt_1.
  - Response: no ready activity while gnt_0 is high; the client 1 burst starts after gnt_0 is low.
- Async reset mid-burst:
  - Stimulus: reset pulse between clock edges during beat 2.
  - Response: all outputs are 0 immediately, without waiting for a clock edge; FSM returns to IDLE.
